// File: rtl/force_overlay_pkg.sv
// Shared types and constants for the force/release overlay.
package force_overlay_pkg;

    // Command opcodes carried on cmd_op.
    typedef enum logic [1:0] {
        OP_NOP     = 2'd0,
        OP_FORCE   = 2'd1,
        OP_RELEASE = 2'd2,
        OP_CHECK   = 2'd3
    } cmd_op_e;

    // Saturation value of the failed-CHECK counter.
    localparam logic [15:0] ERR_MAX = 16'hFFFF;

    // Default overlay width; instances with another WIDTH declare their own
    // command struct with the same field order.
    localparam int FO_WIDTH = 64;

    typedef struct packed {
        cmd_op_e             op;
        logic [FO_WIDTH-1:0] mask;
        logic [FO_WIDTH-1:0] data;
    } force_cmd_t;

    // Increment that sticks at ERR_MAX.
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == ERR_MAX) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/force_cmd_fifo.sv
// Synchronous command FIFO with asynchronous reset, occupancy count and
// full/empty flags. Pointers wrap naturally because DEPTH is a power of two.
module force_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [W-1:0]               push_data,
    input  logic                       pop,
    output logic [W-1:0]               pop_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Storage array; contents need no reset because count guards reads.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; push and pop may coincide.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/force_overlay_ctrl.sv
// Force/release overlay for one design variable. Commands are queued and the
// head command executes on every edge while the queue is non-empty.
// Handshake: a command transfers on a posedge where cmd_valid && cmd_ready;
// cmd_ready depends only on the queue count, never on a same-cycle pop.
module force_overlay_ctrl
    import force_overlay_pkg::*;
#(
    parameter int WIDTH     = 64,
    parameter int CMD_DEPTH = 4,
    parameter int IS_NET    = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             d_valid,
    input  logic [WIDTH-1:0] d_data,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_mask,
    input  logic [WIDTH-1:0] cmd_data,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] force_en,
    output logic             chk_done,
    output logic             chk_pass,
    output logic [15:0]      err_count,
    output logic             busy
);

    localparam int CW = $clog2(CMD_DEPTH) + 1;

    typedef struct packed {
        cmd_op_e          op;
        logic [WIDTH-1:0] mask;
        logic [WIDTH-1:0] data;
    } cmd_t;

    localparam int CMD_W = $bits(cmd_t);

    logic [WIDTH-1:0] nat;
    logic [WIDTH-1:0] fval;
    cmd_t             cmd_in;
    cmd_t             head;
    logic [CMD_W-1:0] fifo_rd;
    logic [CW-1:0]    fifo_count;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             exec;
    logic             chk_ok;

    // NOP commands are accepted but never enter the queue.
    assign cmd_in    = '{op: cmd_op_e'(cmd_op), mask: cmd_mask, data: cmd_data};
    assign cmd_ready = !fifo_full;
    assign push      = cmd_valid && cmd_ready && (cmd_op_e'(cmd_op) != OP_NOP);
    assign busy      = (fifo_count != '0);
    assign exec      = !fifo_empty;
    assign head      = cmd_t'(fifo_rd);

    force_cmd_fifo #(
        .DEPTH (CMD_DEPTH),
        .W     (CMD_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (cmd_in),
        .pop       (exec),
        .pop_data  (fifo_rd),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Forced read path and CHECK comparison, both on the current (pre-edge) q.
    always_comb begin
        q      = (force_en & fval) | (~force_en & nat);
        chk_ok = (((q ^ head.data) & head.mask) == '0);
    end

    // Natural value: design writes win; a variable release latches the forced bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nat <= '0;
        end else if (d_valid) begin
            nat <= d_data;
        end else if (exec && head.op == OP_RELEASE && IS_NET == 0) begin
            nat <= (nat & ~head.mask) | (q & head.mask);
        end
    end

    // Force state updated by FORCE and RELEASE commands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            force_en <= '0;
            fval     <= '0;
        end else if (exec) begin
            if (head.op == OP_FORCE) begin
                force_en <= force_en | head.mask;
                fval     <= (fval & ~head.mask) | (head.data & head.mask);
            end else if (head.op == OP_RELEASE) begin
                force_en <= force_en & ~head.mask;
            end
        end
    end

    // Registered CHECK result and saturating failure counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chk_done  <= 1'b0;
            chk_pass  <= 1'b0;
            err_count <= '0;
        end else begin
            chk_done <= exec && (head.op == OP_CHECK);
            if (exec && head.op == OP_CHECK) begin
                chk_pass <= chk_ok;
                if (!chk_ok) err_count <= sat_inc(err_count);
            end
        end
    end

endmodule

// File: tb/tb_force_overlay_ctrl.sv
// Bench for force_overlay_ctrl: one variable-semantics and one net-semantics
// instance share stimulus and are compared every cycle to a behavioural model.
module tb_force_overlay_ctrl;

    localparam int W     = 32;
    localparam int DEPTH = 4;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] mask;
        logic [W-1:0] data;
    } cmd_t;

    // ---------------- clock / reset / DUT ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic         d_valid;
    logic [W-1:0] d_data;
    logic         cmd_valid;
    logic [1:0]   cmd_op;
    logic [W-1:0] cmd_mask;
    logic [W-1:0] cmd_data;

    logic         ready_o [2];
    logic [W-1:0] q_o     [2];
    logic [W-1:0] fen_o   [2];
    logic         done_o  [2];
    logic         pass_o  [2];
    logic [15:0]  err_o   [2];
    logic         busy_o  [2];

    force_overlay_ctrl #(.WIDTH(W), .CMD_DEPTH(DEPTH), .IS_NET(0)) u_var (
        .clk(clk), .rst(rst), .d_valid(d_valid), .d_data(d_data),
        .cmd_valid(cmd_valid), .cmd_ready(ready_o[0]), .cmd_op(cmd_op),
        .cmd_mask(cmd_mask), .cmd_data(cmd_data), .q(q_o[0]),
        .force_en(fen_o[0]), .chk_done(done_o[0]), .chk_pass(pass_o[0]),
        .err_count(err_o[0]), .busy(busy_o[0])
    );

    force_overlay_ctrl #(.WIDTH(W), .CMD_DEPTH(DEPTH), .IS_NET(1)) u_net (
        .clk(clk), .rst(rst), .d_valid(d_valid), .d_data(d_data),
        .cmd_valid(cmd_valid), .cmd_ready(ready_o[1]), .cmd_op(cmd_op),
        .cmd_mask(cmd_mask), .cmd_data(cmd_data), .q(q_o[1]),
        .force_en(fen_o[1]), .chk_done(done_o[1]), .chk_pass(pass_o[1]),
        .err_count(err_o[1]), .busy(busy_o[1])
    );

    // ---------------- reference model ----------------
    cmd_t         exp_cmd_q[$];
    logic [W-1:0] m_nat  [2];
    logic [W-1:0] m_fen  [2];
    logic [W-1:0] m_fval [2];
    logic [15:0]  m_err  [2];
    logic         m_done [2];
    logic         m_pass [2];

    int n_cmp = 0;
    int n_mis = 0;

    function automatic logic [W-1:0] mq(input int i);
        return (m_fen[i] & m_fval[i]) | (~m_fen[i] & m_nat[i]);
    endfunction

    task automatic model_clear();
        exp_cmd_q.delete();
        for (int i = 0; i < 2; i++) begin
            m_nat[i] = '0; m_fen[i] = '0; m_fval[i] = '0;
            m_err[i] = '0; m_done[i] = 1'b0; m_pass[i] = 1'b0;
        end
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_edge();
        logic [W-1:0] qp;
        cmd_t         h;
        bit           ex;
        bit           acc;
        acc = cmd_valid && (exp_cmd_q.size() != DEPTH);
        ex  = (exp_cmd_q.size() != 0);
        h   = '{op: 2'd0, mask: '0, data: '0};
        if (ex) h = exp_cmd_q[0];
        for (int i = 0; i < 2; i++) begin
            qp = mq(i);
            m_done[i] = 1'b0;
            if (ex && h.op == 2'd2) begin
                m_fen[i] = m_fen[i] & ~h.mask;
                if (i == 0) m_nat[i] = (m_nat[i] & ~h.mask) | (qp & h.mask);
            end
            if (d_valid) m_nat[i] = d_data;
            if (ex && h.op == 2'd1) begin
                m_fen[i]  = m_fen[i] | h.mask;
                m_fval[i] = (m_fval[i] & ~h.mask) | (h.data & h.mask);
            end
            if (ex && h.op == 2'd3) begin
                m_done[i] = 1'b1;
                m_pass[i] = (((qp ^ h.data) & h.mask) == '0);
                if (!m_pass[i] && m_err[i] != 16'hFFFF) m_err[i] = m_err[i] + 16'd1;
            end
        end
        if (ex) void'(exp_cmd_q.pop_front());
        if (acc && cmd_op != 2'd0) exp_cmd_q.push_back('{op: cmd_op, mask: cmd_mask, data: cmd_data});
    endtask

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        for (int i = 0; i < 2; i++) begin
            check_eq($sformatf("q[%0d]", i), q_o[i], mq(i));
            check_eq($sformatf("force_en[%0d]", i), fen_o[i], m_fen[i]);
            check_eq($sformatf("chk_done[%0d]", i), W'(done_o[i]), W'(m_done[i]));
            if (m_done[i]) check_eq($sformatf("chk_pass[%0d]", i), W'(pass_o[i]), W'(m_pass[i]));
            check_eq($sformatf("err_count[%0d]", i), W'(err_o[i]), W'(m_err[i]));
            check_eq($sformatf("busy[%0d]", i), W'(busy_o[i]), W'(exp_cmd_q.size() != 0));
            check_eq($sformatf("cmd_ready[%0d]", i), W'(ready_o[i]), W'(exp_cmd_q.size() != DEPTH));
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        d_valid = 1'b0; d_data = '0;
        cmd_valid = 1'b0; cmd_op = 2'd0; cmd_mask = '0; cmd_data = '0;
    endtask

    // One clock: model the edge, let it happen, compare on the falling edge.
    task automatic tick();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        #1;
        model_clear();
        check_outputs();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic push_cmd(input logic [1:0] op, input logic [W-1:0] mask, input logic [W-1:0] data);
        bit taken;
        taken = 1'b0;
        cmd_valid = 1'b1; cmd_op = op; cmd_mask = mask; cmd_data = data;
        for (int t = 0; t < 16 && !taken; t++) begin
            taken = (exp_cmd_q.size() != DEPTH);
            tick();
        end
        if (!taken) check_eq("push_timeout", '0, '1);
        cmd_valid = 1'b0;
    endtask

    task automatic load(input logic [W-1:0] v);
        d_valid = 1'b1; d_data = v;
        tick();
        d_valid = 1'b0;
    endtask

    task automatic drain();
        for (int t = 0; t < 16 && exp_cmd_q.size() != 0; t++) tick();
        if (exp_cmd_q.size() != 0) check_eq("drain_timeout", '0, '1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        idle_inputs();
        model_clear();
        #2;
        do_reset();

        // Load and read.
        load(32'hAAAAAAAA);
        check_eq("t1_q_var", q_o[0], 32'hAAAAAAAA);
        check_eq("t1_fen", fen_o[0], 32'h0);

        // Full force, then a design write underneath it.
        push_cmd(2'd1, 32'hFFFFFFFF, 32'h55555555);
        load(32'hAAAAAAAA);
        check_eq("t2_q_forced", q_o[0], 32'h55555555);
        tick();
        check_eq("t2_q_hold", q_o[1], 32'h55555555);
        push_cmd(2'd3, 32'hFFFFFFFF, 32'h55555555);
        tick();
        check_eq("t2_chk_done", W'(done_o[0]), W'(1));
        check_eq("t2_chk_pass", W'(pass_o[0]), W'(1));

        // Partial force.
        do_reset();
        load(32'hAAAAAAAA);
        push_cmd(2'd1, 32'h0000FFFF, 32'h00005555);
        tick();
        check_eq("t3_q_partial", q_o[0], 32'hAAAA5555);
        push_cmd(2'd3, 32'hFFFFFFFF, 32'hAAAA5555);
        tick();
        check_eq("t3_pass", W'(pass_o[0]), W'(1));
        push_cmd(2'd3, 32'hFFFFFFFF, 32'h55555555);
        tick();
        check_eq("t3_fail", W'(pass_o[0]), W'(0));
        check_eq("t3_err", W'(err_o[0]), W'(1));

        // Release semantics: variable holds, net reverts.
        push_cmd(2'd1, 32'hFFFFFFFF, 32'h55555555);
        push_cmd(2'd2, 32'hFFFFFFFF, 32'h0);
        tick();
        check_eq("t4_var_hold", q_o[0], 32'h55555555);
        check_eq("t4_net_revert", q_o[1], 32'hAAAAAAAA);
        tick();
        check_eq("t4_var_hold2", q_o[0], 32'h55555555);
        load(32'hAAAAAAAA);
        check_eq("t4_var_reload", q_o[0], 32'hAAAAAAAA);

        // Back-to-back commands executed in order; masks of zero are no-ops.
        cmd_valid = 1'b1;
        cmd_op = 2'd1; cmd_mask = 32'h000000FF; cmd_data = 32'h00000011; tick();
        cmd_op = 2'd1; cmd_mask = 32'h0000000F; cmd_data = 32'h00000002; tick();
        cmd_op = 2'd2; cmd_mask = 32'h00000001; cmd_data = 32'h0;        tick();
        cmd_op = 2'd1; cmd_mask = 32'h0;        cmd_data = 32'hFFFFFFFF; tick();
        cmd_op = 2'd3; cmd_mask = 32'h0;        cmd_data = 32'h12345678; tick();
        cmd_op = 2'd0; cmd_mask = 32'hFFFFFFFF; cmd_data = 32'hFFFFFFFF; tick();
        cmd_valid = 1'b0;
        drain();
        check_eq("t5_order_q", q_o[1], 32'hAAAAAA12);
        check_eq("t5_order_fen", fen_o[1], 32'h000000FE);
        check_eq("t5_mask0_pass", W'(pass_o[0]), W'(1));

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            d_valid   = ($urandom_range(0, 2) == 0);
            d_data    = $urandom;
            cmd_valid = ($urandom_range(0, 3) != 0);
            cmd_op    = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 5))
                0:       cmd_mask = '0;
                1:       cmd_mask = '1;
                default: cmd_mask = $urandom;
            endcase
            cmd_data = ($urandom_range(0, 1) == 0) ? mq(0) : $urandom;
            tick();
        end
        idle_inputs();
        drain();

        // err_count saturation: stream failing CHECKs until it pegs.
        do_reset();
        cmd_valid = 1'b1; cmd_op = 2'd3; cmd_mask = 32'h1; cmd_data = 32'h1;
        for (int t = 0; t < 70000 && m_err[0] != 16'hFFFE; t++) tick();
        check_eq("sat_fffe", W'(err_o[0]), W'(16'hFFFE));
        tick(); tick(); tick();
        cmd_valid = 1'b0;
        drain();
        check_eq("sat_ffff", W'(err_o[0]), W'(16'hFFFF));
        check_eq("sat_ffff_net", W'(err_o[1]), W'(16'hFFFF));

        // Reset with commands still queued.
        do_reset();
        cmd_valid = 1'b1;
        cmd_op = 2'd1; cmd_mask = 32'h000000FF; cmd_data = 32'h000000C3; tick();
        cmd_op = 2'd1; cmd_mask = 32'h0000FF00; cmd_data = 32'h0000A500; tick();
        check_eq("t6_first_exec", fen_o[0], 32'h000000FF);
        cmd_op = 2'd1; cmd_mask = 32'hFF000000; cmd_data = 32'h5A000000;
        do_reset();
        check_eq("t6_q", q_o[0], 32'h0);
        check_eq("t6_fen", fen_o[0], 32'h0);
        check_eq("t6_busy", W'(busy_o[0]), W'(0));
        tick();
        load(32'h12345678);
        check_eq("t6_unforced", q_o[0], 32'h12345678);
        check_eq("t6_unforced_net", q_o[1], 32'h12345678);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
